// File: rtl/payment_ctrl.sv
// payment_ctrl -- ticket vending payment controller.
//
// Accepts an order (price + ticket count), collects coins into a saturating
// running total, then releases one ticket_pulse per ticket, one change_pulse
// per unit of change (or of refund on cancel) and finally a one-cycle done.
//
// Ports:
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   order_valid  : one-cycle order request, samples total/ticket
//   total        : order price (DW bits)
//   ticket       : ticket count (DW bits)
//   coin_valid   : qualifies coin
//   coin         : coin value (DW bits)
//   cancel       : passenger abort (honoured only while paying)
//   busy         : high whenever the FSM is not in IDLE
//   paid         : running amount inserted, held after the transaction
//   ticket_pulse : one cycle per ticket released
//   change_pulse : one cycle per unit of change/refund released
//   coin_reject  : coin offered outside PAY was ignored
//   done         : one-cycle end-of-transaction pulse
//
// Optional feature: define PAYMENT_TIMEOUT_EN to add an 8-bit idle counter
// that refunds the passenger after 255 PAY cycles without a coin.
module payment_ctrl #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          order_valid,
   input  logic [DW-1:0] total,
   input  logic [DW-1:0] ticket,
   input  logic          coin_valid,
   input  logic [DW-1:0] coin,
   input  logic          cancel,
   output logic          busy,
   output logic [DW-1:0] paid,
   output logic          ticket_pulse,
   output logic          change_pulse,
   output logic          coin_reject,
   output logic          done
);

   typedef enum logic [2:0] {IDLE, PAY, DISPENSE, CHANGE, FINISH} state_t;

   localparam logic [DW-1:0] ONE = DW'(1);

   state_t        state_q, state_d;
   logic [DW-1:0] total_q, total_d;
   logic [DW-1:0] paid_q, paid_d;
   logic [DW-1:0] change_left_q, change_left_d;
   logic [DW-1:0] tickets_left_q, tickets_left_d;
   logic          busy_q, busy_d;
   logic          ticket_pulse_q, ticket_pulse_d;
   logic          change_pulse_q, change_pulse_d;
   logic          coin_reject_q, coin_reject_d;
   logic          done_q, done_d;

   logic [DW:0]   sum;
   logic [DW-1:0] new_paid;
   logic          cancel_eff;

`ifdef PAYMENT_TIMEOUT_EN
   logic [7:0]    idle_cnt_q, idle_cnt_d;
`endif

   always_comb begin
      state_d        = state_q;
      total_d        = total_q;
      paid_d         = paid_q;
      change_left_d  = change_left_q;
      tickets_left_d = tickets_left_q;
      ticket_pulse_d = 1'b0;
      change_pulse_d = 1'b0;
      done_d         = 1'b0;
      coin_reject_d  = coin_valid && (state_q != PAY);

      // Extra carry bit detects overflow so paid saturates instead of wrapping.
      sum      = {1'b0, paid_q} + {1'b0, coin};
      new_paid = coin_valid ? (sum[DW] ? '1 : sum[DW-1:0]) : paid_q;

`ifdef PAYMENT_TIMEOUT_EN
      idle_cnt_d = idle_cnt_q;
      cancel_eff = cancel || (idle_cnt_q == 8'hFF);
`else
      cancel_eff = cancel;
`endif

      case (state_q)
         IDLE: begin
            if (order_valid && (total != '0) && (ticket != '0)) begin
               total_d        = total;
               tickets_left_d = ticket;
               change_left_d  = '0;
               paid_d         = '0;
               state_d        = PAY;
`ifdef PAYMENT_TIMEOUT_EN
               idle_cnt_d     = 8'd0;
`endif
            end
         end
         PAY: begin
            paid_d = new_paid;
`ifdef PAYMENT_TIMEOUT_EN
            idle_cnt_d = coin_valid ? 8'd0 : idle_cnt_q + 8'd1;
`endif
            // Cancel has priority over completion: the coin of the same cycle
            // is still counted, then everything is refunded.
            if (cancel_eff) begin
               change_left_d  = new_paid;
               tickets_left_d = '0;
               state_d        = CHANGE;
            end else if (coin_valid && (new_paid >= total_q)) begin
               change_left_d = new_paid - total_q;
               state_d       = DISPENSE;
            end
         end
         DISPENSE: begin
            if (tickets_left_q != '0) begin
               ticket_pulse_d = 1'b1;
               tickets_left_d = tickets_left_q - ONE;
            end
            // Leave on the cycle that issues the last pulse so the pulses
            // form one unbroken run.
            if (tickets_left_q <= ONE) begin
               state_d = CHANGE;
            end
         end
         CHANGE: begin
            if (change_left_q != '0) begin
               change_pulse_d = 1'b1;
               change_left_d  = change_left_q - ONE;
            end
            if (change_left_q <= ONE) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Registered from the next state so busy tracks the state register.
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         total_q        <= '0;
         paid_q         <= '0;
         change_left_q  <= '0;
         tickets_left_q <= '0;
         busy_q         <= 1'b0;
         ticket_pulse_q <= 1'b0;
         change_pulse_q <= 1'b0;
         coin_reject_q  <= 1'b0;
         done_q         <= 1'b0;
`ifdef PAYMENT_TIMEOUT_EN
         idle_cnt_q     <= 8'd0;
`endif
      end else begin
         state_q        <= state_d;
         total_q        <= total_d;
         paid_q         <= paid_d;
         change_left_q  <= change_left_d;
         tickets_left_q <= tickets_left_d;
         busy_q         <= busy_d;
         ticket_pulse_q <= ticket_pulse_d;
         change_pulse_q <= change_pulse_d;
         coin_reject_q  <= coin_reject_d;
         done_q         <= done_d;
`ifdef PAYMENT_TIMEOUT_EN
         idle_cnt_q     <= idle_cnt_d;
`endif
      end
   end

   assign busy         = busy_q;
   assign paid         = paid_q;
   assign ticket_pulse = ticket_pulse_q;
   assign change_pulse = change_pulse_q;
   assign coin_reject  = coin_reject_q;
   assign done         = done_q;

endmodule

// File: tb/tb_payment_ctrl.sv
// tb_payment_ctrl -- scoreboard bench for payment_ctrl (DW = 8).
// Stimulus pushes the expected pulse sequence (kind + paid value) into a
// queue; a monitor pops one entry per observed output pulse and compares.
module tb_payment_ctrl;

   localparam int DW = 8;

   localparam logic [3:0] K_T = 4'b0001;   // ticket_pulse
   localparam logic [3:0] K_C = 4'b0010;   // change_pulse
   localparam logic [3:0] K_D = 4'b0100;   // done
   localparam logic [3:0] K_R = 4'b1000;   // coin_reject

   typedef struct {
      logic [3:0]    kind;
      logic [DW-1:0] paid;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          order_valid;
   logic [DW-1:0] total;
   logic [DW-1:0] ticket;
   logic          coin_valid;
   logic [DW-1:0] coin;
   logic          cancel;
   logic          busy;
   logic [DW-1:0] paid;
   logic          ticket_pulse;
   logic          change_pulse;
   logic          coin_reject;
   logic          done;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   payment_ctrl #(.DW(DW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .order_valid  (order_valid),
      .total        (total),
      .ticket       (ticket),
      .coin_valid   (coin_valid),
      .coin         (coin),
      .cancel       (cancel),
      .busy         (busy),
      .paid         (paid),
      .ticket_pulse (ticket_pulse),
      .change_pulse (change_pulse),
      .coin_reject  (coin_reject),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [3:0] kind, input logic [DW-1:0] p, input int n);
      ev_t e;
      e.kind = kind;
      e.paid = p;
      for (int i = 0; i < n; i++) exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs, starting just after a rising edge.
   task automatic cycle(input logic ov, input logic [DW-1:0] t, input logic [DW-1:0] k,
                        input logic cv, input logic [DW-1:0] c, input logic cn);
      order_valid = ov;
      total       = t;
      ticket      = k;
      coin_valid  = cv;
      coin        = c;
      cancel      = cn;
      @(posedge clk);
      #1;
      order_valid = 1'b0;
      total       = '0;
      ticket      = '0;
      coin_valid  = 1'b0;
      coin        = '0;
      cancel      = 1'b0;
   endtask

   // Wait (bounded) until the DUT is idle and every expected pulse was seen.
   task automatic wait_idle(input string name, input int limit);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check({name, "_completes"}, 32'(!busy && exp_q.size() == 0), 32'd1);
      $display("txn %s: finished after %0d cycles, paid=%0d", name, n, paid);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every output pulse must match the head of the queue.
   initial begin
      logic [3:0] obs;
      ev_t        e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            obs = {coin_reject, done, change_pulse, ticket_pulse};
            if (obs != 4'b0) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_pulse", 32'(obs), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("pulse_kind", 32'(obs), 32'(e.kind));
                  check("pulse_paid", 32'(paid), 32'(e.paid));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, got busy=%0d, expected idle", busy);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      order_valid = 1'b0; total = '0; ticket = '0;
      coin_valid = 1'b0; coin = '0; cancel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_paid", 32'(paid), 32'd0);
      check("reset_pulses", 32'({coin_reject, done, change_pulse, ticket_pulse}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Exact payment: 6 / 2 tickets, coins 5 + 1.
      push(K_T, 8'd6, 2); push(K_D, 8'd6, 1);
      cycle(1'b1, 8'd6, 8'd2, 1'b0, 8'd0, 1'b0);
      check("busy_after_order", 32'(busy), 32'd1);
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd5, 1'b0);
      check("paid_after_coin5", 32'(paid), 32'd5);
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd1, 1'b0);
      wait_idle("exact", 100);

      // Overpay: 6 / 2 tickets, coins 5 + 5 -> 4 change.
      push(K_T, 8'd10, 2); push(K_C, 8'd10, 4); push(K_D, 8'd10, 1);
      cycle(1'b1, 8'd6, 8'd2, 1'b0, 8'd0, 1'b0);
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd5, 1'b0);
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd5, 1'b0);
      wait_idle("overpay", 100);

      // Cancel: 8 / 4 tickets, coin 3, then cancel -> refund 3.
      push(K_C, 8'd3, 3); push(K_D, 8'd3, 1);
      cycle(1'b1, 8'd8, 8'd4, 1'b0, 8'd0, 1'b0);
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd3, 1'b0);
      cycle(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);
      wait_idle("cancel", 100);

      // Coin 5 and cancel together on a 4 / 1 order -> refund 5, no ticket.
      push(K_C, 8'd5, 5); push(K_D, 8'd5, 1);
      cycle(1'b1, 8'd4, 8'd1, 1'b0, 8'd0, 1'b0);
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd5, 1'b1);
      wait_idle("coin_and_cancel", 100);

      // Coin in IDLE is rejected and paid keeps its last value.
      push(K_R, 8'd5, 1);
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd2, 1'b0);
      wait_idle("idle_reject", 10);

      // Saturation: 255 / 1, coins 250 + 20 -> paid 255, no change.
      push(K_T, 8'd255, 1); push(K_D, 8'd255, 1);
      cycle(1'b1, 8'd255, 8'd1, 1'b0, 8'd0, 1'b0);
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd250, 1'b0);
      check("paid_250", 32'(paid), 32'd250);
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd20, 1'b0);
      check("paid_saturated", 32'(paid), 32'd255);
      wait_idle("saturate", 100);

      // Idle timeout: 6 / 2, coin 2, then no activity.
`ifdef PAYMENT_TIMEOUT_EN
      push(K_C, 8'd2, 2); push(K_D, 8'd2, 1);
      cycle(1'b1, 8'd6, 8'd2, 1'b0, 8'd0, 1'b0);
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd2, 1'b0);
      wait_idle("timeout", 400);
`else
      cycle(1'b1, 8'd6, 8'd2, 1'b0, 8'd0, 1'b0);
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd2, 1'b0);
      repeat (300) @(posedge clk);
      #1;
      check("no_timeout_busy", 32'(busy), 32'd1);
      check("no_timeout_paid", 32'(paid), 32'd2);
      push(K_C, 8'd2, 2); push(K_D, 8'd2, 1);
      cycle(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);
      wait_idle("no_timeout", 100);
`endif

      // Zero-price / zero-ticket orders and an idle cancel are ignored.
      cycle(1'b1, 8'd0, 8'd3, 1'b0, 8'd0, 1'b0);
      cycle(1'b1, 8'd5, 8'd0, 1'b0, 8'd0, 1'b0);
      cycle(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);
      repeat (2) @(negedge clk);
      check("ignored_busy", 32'(busy), 32'd0);
      check("ignored_paid", 32'(paid), 32'd2);
      $display("txn ignored_orders: busy=%0d paid=%0d", busy, paid);
      @(posedge clk);
      #1;

      // Reset mid-transaction clears asynchronously; nothing more is emitted.
      cycle(1'b1, 8'd8, 8'd4, 1'b0, 8'd0, 1'b0);
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd3, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_paid", 32'(paid), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      $display("txn mid_reset: busy=%0d paid=%0d", busy, paid);
      @(posedge clk);
      #1;

      // First order after reset is accepted normally: 3 / 1, coin 3.
      push(K_T, 8'd3, 1); push(K_D, 8'd3, 1);
      cycle(1'b1, 8'd3, 8'd1, 1'b0, 8'd0, 1'b0);
      cycle(1'b0, 8'd0, 8'd0, 1'b1, 8'd3, 1'b0);
      wait_idle("after_reset", 100);

      repeat (3) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
